// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the local-RAM arbiter/controller.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_B:    lane_mask = 4'b0001 << a;
      SZ_H:    lane_mask = 4'b0011 << a;
      SZ_W:    lane_mask = 4'hF;
      default: lane_mask = 4'h0;
    endcase
  endfunction

  // Right-align the addressed lanes, then zero- or sign-extend to a full word.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                              input logic [1:0] a, input logic uns);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (sz)
      SZ_B:    load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Word-organised synchronous RAM with byte-lane write enables and registered read.
module mem_bank #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic                         re,
  input  logic [$clog2(DEPTH)-1:0]     idx,
  input  logic [4*BYTE_WIDTH-1:0]      wdata,
  output logic [4*BYTE_WIDTH-1:0]      rdata
);

  logic [4*BYTE_WIDTH-1:0] mem [DEPTH];
  logic [4*BYTE_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_arb_ctl.sv
// Round-robin arbiter and single-outstanding access FSM in front of one local RAM.
module mem_arb_ctl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned SIZE       = 4096,
  parameter int unsigned NCH        = 2
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NCH-1:0]             req_valid,
  output logic [NCH-1:0]             req_ready,
  input  logic [NCH-1:0]             req_rw,
  input  logic [2*NCH-1:0]           req_size,
  input  logic [NCH-1:0]             req_uns,
  input  logic [ADDR_WIDTH*NCH-1:0]  req_addr,
  input  logic [DATA_WIDTH*NCH-1:0]  req_wdata,
  output logic [NCH-1:0]             rsp_valid,
  input  logic [NCH-1:0]             rsp_ready,
  output logic [DATA_WIDTH*NCH-1:0]  rsp_rdata,
  output logic [NCH-1:0]             rsp_err
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BW = $clog2(SIZE);

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("mem_arb_ctl: DATA_WIDTH must be 32");
  end
  if (BYTE_WIDTH != 8) begin : g_bad_bw
    $error("mem_arb_ctl: BYTE_WIDTH must be 8");
  end
  if ((SIZE & (SIZE - 1)) != 0 || SIZE < 4) begin : g_bad_size
    $error("mem_arb_ctl: SIZE must be a power of 2 and a multiple of 4");
  end
  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("mem_arb_ctl: NCH must be 1..4");
  end

  state_e                  state_q, state_d;
  logic [PW-1:0]           rr_q, rr_d, gnt_q, gnt_d;
  logic                    rw_q, rw_d, uns_q, uns_d, err_q, err_d;
  size_e                   size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    found;
  logic [PW-1:0]           sel;
  logic                    acc_err;
  logic                    rsp_ack;
  logic                    ram_we, ram_re;
  logic [3:0]              ram_be;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata, rdata_sel;

  // Two passes give "first valid at or above rr_q, else first below" without modulo indexing.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && req_valid[c] && c >= 32'(rr_q)) begin
        found = 1'b1;
        sel   = PW'(c);
      end
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && req_valid[c] && c < 32'(rr_q)) begin
        found = 1'b1;
        sel   = PW'(c);
      end
    end
  end

  assign acc_err = (size_q == SZ_X)
                 | ((size_q == SZ_H) & addr_q[0])
                 | ((size_q == SZ_W) & (addr_q[1:0] != 2'b00))
                 | (addr_q >= ADDR_WIDTH'(SIZE));

  assign ram_we    = (state_q == ACCESS) & ~acc_err & rw_q;
  assign ram_re    = (state_q == ACCESS) & ~acc_err & ~rw_q;
  assign ram_be    = lane_mask(size_q, addr_q[1:0]);
  assign ram_wdata = wdata_q << (BYTE_WIDTH * addr_q[1:0]);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    rw_d      = rw_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_ack   = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (gnt_q == PW'(c)) rsp_ack = rsp_ready[c];
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          for (int unsigned c = 0; c < NCH; c++) begin
            if (sel == PW'(c)) begin
              req_ready[c] = sys_rst;
              rw_d         = req_rw[c];
              size_d       = size_e'(req_size[2*c +: 2]);
              uns_d        = req_uns[c];
              addr_d       = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d      = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          gnt_d   = sel;
          rr_d    = (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = acc_err;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_bank #(
    .DEPTH      (SIZE / 4),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_bank (
    .clk   (sys_clk),
    .we    (ram_we),
    .be    (ram_be),
    .re    (ram_re),
    .idx   (addr_q[BW-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The bank only re-reads in ACCESS, so its output stays stable for the whole RESP hold.
  always_comb begin
    rdata_sel = (err_q | rw_q) ? '0 : load_extend(ram_rdata, size_q, addr_q[1:0], uns_q);
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (state_q == RESP && gnt_q == PW'(c)) begin
        rsp_valid[c]                          = 1'b1;
        rsp_rdata[c*DATA_WIDTH +: DATA_WIDTH] = rdata_sel;
        rsp_err[c]                            = err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb_ctl.sv
// Randomized and directed checks of mem_arb_ctl against a byte-array memory model.
module tb_mem_arb_ctl;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_rw, req_uns, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata, rsp_rdata;

  int checks = 0;
  int failures = 0;
  int rr_m = 0;
  logic [7:0] mem_m [0:4095];

  typedef struct {
    bit        rw;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] rd;
    bit        err;
  } case_t;

  mem_arb_ctl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8),
    .SIZE       (4096),
    .NCH        (2)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_size  (req_size),
    .req_uns   (req_uns),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-addressed little-endian memory, arithmetic sign extension.
  function automatic void model(input bit rw, input bit [1:0] sz, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output bit er, output logic [31:0] rd);
    int unsigned n;
    longint v;
    n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    er = (sz == 3) || (addr % n != 0) || (addr >= 4096);
    rd = '0;
    if (er) return;
    if (rw) begin
      for (int unsigned i = 0; i < n; i++) mem_m[addr + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int unsigned i = 0; i < n; i++) v = v | (longint'(mem_m[addr + i]) << (8*i));
      if (!uns && ((v >> (8*n - 1)) & 1) == 1) v = v - (longint'(1) << (8*n));
      rd = v[31:0];
    end
  endfunction

  task automatic set_req(input int ch, input bit rw, input bit [1:0] sz, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wd);
    req_rw[ch]             = rw;
    req_size[2*ch +: 2]    = sz;
    req_uns[ch]            = uns;
    req_addr[32*ch +: 32]  = addr;
    req_wdata[32*ch +: 32] = wd;
  endtask

  task automatic txn(input int ch, input bit rw, input bit [1:0] sz, input bit uns,
                     input bit [31:0] addr, input bit [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat, output bit to);
    int n;
    to = 0; rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    set_req(ch, rw, sz, uns, addr, wd);
    req_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[ch] && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready[ch]) begin to = 1; req_valid[ch] = 1'b0; return; end
    rr_m = (ch + 1) % 2;
    do begin
      @(negedge clk);
      if (lat == 0) req_valid[ch] = 1'b0;
      #1;
      lat++;
    end while (!rsp_valid[ch] && lat < 50);
    if (!rsp_valid[ch]) to = 1;
    rd = rsp_rdata[32*ch +: 32];
    er = rsp_err[ch];
  endtask

  task automatic test_reset();
    req_valid = '0; req_rw = '0; req_uns = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 2'b00) begin failures++; $display("FAIL reset_rsp_err got=%b exp=00", rsp_err); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
  endtask

  task automatic test_preload();
    logic [31:0] rd, erd; logic er; bit emerr; int lat; bit to; bit [31:0] wd;
    for (int a = 0; a < 256; a += 4) begin
      wd = $urandom;
      model(1'b1, 2'd2, 1'b0, a, wd, emerr, erd);
      txn(0, 1'b1, 2'd2, 1'b0, a, wd, rd, er, lat, to);
      checks++; if (to || er !== 1'b0) begin failures++; $display("FAIL preload_write addr=%h to=%0d err=%b exp_err=0", a, to, er); end
    end
  endtask

  task automatic test_directed();
    case_t tbl [14] = '{
      '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0},
      '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h0000DEAD, 1'b0},
      '{1'b1, 2'd0, 1'b0, 32'h11,   32'hAABBCC55, 32'h0,        1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1},
      '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1},
      '{1'b1, 2'd2, 1'b0, 32'h12,   32'h12345678, 32'h0,        1'b1},
      '{1'b1, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1},
      '{1'b1, 2'd2, 1'b0, 32'h1010, 32'hFFFFFFFF, 32'h0,        1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0}
    };
    logic [31:0] rd, mrd; logic er; bit mer; int lat; bit to;
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].rw, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, mer, mrd);
      txn(1, tbl[i].rw, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rd, er, lat, to);
      checks++; if (to) begin failures++; $display("FAIL dir_timeout case=%0d got=timeout exp=response", i); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL dir_latency case=%0d got=%0d exp=2", i, lat); end
      checks++; if (er !== tbl[i].err) begin failures++; $display("FAIL dir_err case=%0d got=%b exp=%b", i, er, tbl[i].err); end
      checks++; if (rd !== tbl[i].rd) begin failures++; $display("FAIL dir_rdata case=%0d got=%h exp=%h", i, rd, tbl[i].rd); end
    end
    model(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, mer, mrd);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat, to);
    checks++; if (to || rd !== mrd) begin failures++; $display("FAIL dir_word0_intact got=%h exp=%h", rd, mrd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd; logic er; bit mer; int lat; bit to;
    bit rw, uns; bit [1:0] sz; bit [31:0] addr, wd; int ch;
    for (int i = 0; i < 60; i++) begin
      ch   = $urandom_range(0, 1);
      rw   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      addr = ($urandom_range(0, 7) == 0) ? 32'(4096 + $urandom_range(0, 255)) : 32'($urandom_range(0, 255));
      model(rw, sz, uns, addr, wd, mer, mrd);
      txn(ch, rw, sz, uns, addr, wd, rd, er, lat, to);
      checks++; if (to || lat !== 2) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d to=%0d exp=2", i, lat, to); end
      checks++; if (er !== mer) begin failures++; $display("FAIL rnd_err i=%0d addr=%h sz=%0d got=%b exp=%b", i, addr, sz, er, mer); end
      checks++; if (rd !== mrd) begin failures++; $display("FAIL rnd_rdata i=%0d addr=%h sz=%0d uns=%0d got=%h exp=%h", i, addr, sz, uns, rd, mrd); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e0, e1, ev; bit er; int got, exp_g, g, cyc;
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, e0);
    model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, e1);
    @(negedge clk);
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    req_valid = 2'b11;
    exp_g = rr_m; got = 0; cyc = 0;
    while (got < 6 && cyc < 200) begin
      #1;
      checks++; if ($countones(req_ready) > 1) begin failures++; $display("FAIL rr_ready_onehot got=%b exp=at_most_one", req_ready); end
      checks++; if ($countones(rsp_valid) > 1) begin failures++; $display("FAIL rr_rsp_onehot got=%b exp=at_most_one", rsp_valid); end
      if (rsp_valid != 2'b00) begin
        g  = rsp_valid[1] ? 1 : 0;
        ev = g ? e1 : e0;
        checks++; if (rsp_rdata[32*g +: 32] !== ev) begin failures++; $display("FAIL rr_rdata ch=%0d got=%h exp=%h", g, rsp_rdata[32*g +: 32], ev); end
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        checks++; if (g !== exp_g) begin failures++; $display("FAIL rr_grant n=%0d got=%0d exp=%0d", got, g, exp_g); end
        exp_g = 1 - g; rr_m = 1 - g; got++;
      end
      @(negedge clk); cyc++;
    end
    req_valid = 2'b00;
    checks++; if (got != 6) begin failures++; $display("FAIL rr_grant_count got=%0d exp=6", got); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] e0, e1, r0; bit er; int n;
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, e0);
    model(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, er, e1);
    @(negedge clk);
    rsp_ready = 2'b10;
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    req_valid = 2'b01;
    #1; n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_grant0 got=%b exp=1", req_ready[0]); end
    @(negedge clk);
    req_valid = 2'b10;
    #1; n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); #1; n++; end
    r0 = rsp_rdata[31:0];
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, rsp_valid[0]); end
      checks++; if (rsp_rdata[31:0] !== e0 || r0 !== e0) begin failures++; $display("FAIL bp_hold_rdata cyc=%0d got=%h exp=%h", i, rsp_rdata[31:0], e0); end
      checks++; if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_other_ready cyc=%0d got=%b exp=0", i, req_ready[1]); end
      @(negedge clk); #1;
    end
    rsp_ready = 2'b11;
    n = 0;
    while (!req_ready[1] && n < 10) begin @(negedge clk); #1; n++; end
    checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_grant1_after got=%b exp=1", req_ready[1]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL bp_rsp0_cleared got=%b exp=0", rsp_valid[0]); end
    rr_m = 0;
    @(negedge clk);
    req_valid = 2'b00;
    #1; n = 0;
    while (!rsp_valid[1] && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[63:32] !== e1) begin failures++; $display("FAIL bp_ch1_rdata got=%h exp=%h", rsp_rdata[63:32], e1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] e0; bit er; int n;
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, e0);
    @(negedge clk);
    rsp_ready = 2'b01;
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req_valid = 2'b10;
    #1; n = 0;
    while (!req_ready[1] && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req_valid = 2'b00;
    #1; n = 0;
    while (!rsp_valid[1] && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (rsp_valid[1] !== 1'b1) begin failures++; $display("FAIL rst_resp_reached got=%b exp=1", rsp_valid[1]); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_async_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin failures++; $display("FAIL rst_async_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 2'b00) begin failures++; $display("FAIL rst_async_err got=%b exp=00", rsp_err); end
    @(negedge clk);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1; n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[31:0] !== e0) begin failures++; $display("FAIL rst_ram_intact got=%h exp=%h", rsp_rdata[31:0], e0); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_directed();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
